pll_phase_ctrl: RTL and testbench

- Sequences the ECP5 EHXPLLL: drives PLL reset at start-up, waits for lock, and generates dynamic phase-shift pulses (PHASESEL/PHASEDIR/PHASESTEP) on request.
- A single requester (camera/video timing alignment logic) asks for N phase steps on one PLL output.
- Monitors lock continuously and re-runs the reset sequence on lock loss.
- Sits beside the PLL instance in the clock-generation wrapper and runs on the reference-clock domain.

---
 rtl/pll_phase_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - ECP5 EHXPLLL reset/lock sequencer and phase stepper; PLL_PHASE_SETTLE_EN adds a post-step settle state
module pll_phase_ctrl #(
   parameter int STEPS_W      = 8,
   parameter int STEP_SETUP   = 2,
   parameter int STEP_PULSE   = 2,
   parameter int STEP_GAP     = 4,
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic [1:0]         i_req_sel,
   input  logic               i_req_dir,
   input  logic [STEPS_W-1:0] i_req_steps,
   output logic               o_done,
   output logic               o_abort,
   output logic               o_busy,
   output logic               o_locked,
   output logic               o_lock_err,
   input  logic               i_pll_lock,
   output logic               o_pll_rst,
   output logic [1:0]         o_phasesel,
   output logic               o_phasedir,
   output logic               o_phasestep
);

   localparam int MAX_RL  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_SP  = (STEP_SETUP > STEP_PULSE) ? STEP_SETUP : STEP_PULSE;
   localparam int MAX_SG  = (MAX_SP > STEP_GAP) ? MAX_SP : STEP_GAP;
   localparam int MAX_T   = (MAX_RL > MAX_SG) ? MAX_RL : MAX_SG;
   localparam int MAX_ALL = (MAX_T > 64) ? MAX_T : 64;
   localparam int CNT_W   = $clog2(MAX_ALL + 1);

   localparam logic [CNT_W-1:0] C_RST   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_LOCK  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(STEP_SETUP - 1);
   localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(STEP_PULSE - 1);
   localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(STEP_GAP - 1);

   typedef enum logic [3:0] {
      S_RESET, S_WAIT_LOCK, S_IDLE, S_SETUP, S_PULSE, S_GAP, S_SETTLE, S_DONE, S_ABORT
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_lock_meta;
   logic               r_lock_s;
   logic [CNT_W-1:0]   r_cnt;
   logic [STEPS_W-1:0] r_rem;
   logic               w_accept;
   logic               w_err_set;
   logic               w_rem_dec;

`ifdef PLL_PHASE_SETTLE_EN
   localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(15);
   logic [6:0] r_low;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= i_pll_lock;
         r_lock_s    <= r_lock_meta;
      end
   end

   // Every timed state starts counting from zero on entry.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_RESET;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= '0;
`ifdef PLL_PHASE_SETTLE_EN
         else if (r_state == S_SETTLE && !r_lock_s)
            r_cnt <= '0;
`endif
         else
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rem      <= '0;
         o_phasesel <= 2'b00;
         o_phasedir <= 1'b0;
         o_lock_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rem      <= i_req_steps;
            o_phasesel <= i_req_sel;
            o_phasedir <= i_req_dir;
         end else if (w_rem_dec) begin
            r_rem <= r_rem - STEPS_W'(1);
         end
         if (w_err_set)
            o_lock_err <= 1'b1;
      end
   end

`ifdef PLL_PHASE_SETTLE_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_low <= '0;
      else if (r_state == S_SETTLE && !r_lock_s)
         r_low <= r_low + 7'd1;
      else
         r_low <= '0;
   end
`endif

   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_err_set   = 1'b0;
      w_rem_dec   = 1'b0;
      o_pll_rst   = 1'b0;
      o_req_ready = 1'b0;
      o_done      = 1'b0;
      o_abort     = 1'b0;
      o_busy      = 1'b0;
      o_locked    = 1'b0;
      o_phasestep = 1'b0;
      case (r_state)
         S_RESET: begin
            o_pll_rst = 1'b1;
            if (r_cnt == C_RST)
               w_next = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (r_lock_s) begin
               w_next = S_IDLE;
            end else if (r_cnt == C_LOCK) begin
               w_err_set = 1'b1;
               w_next    = S_RESET;
            end
         end
         S_IDLE: begin
            o_locked    = r_lock_s;
            o_req_ready = r_lock_s;
            if (!r_lock_s) begin
               w_next = S_RESET;
            end else if (i_req_valid) begin
               w_accept = 1'b1;
               w_next   = (i_req_steps == '0) ? S_DONE : S_SETUP;
            end
         end
         S_SETUP: begin
            o_busy   = 1'b1;
            o_locked = r_lock_s;
            if (!r_lock_s)
               w_next = S_ABORT;
            else if (r_cnt == C_SETUP)
               w_next = S_PULSE;
         end
         S_PULSE: begin
            o_busy      = 1'b1;
            o_locked    = r_lock_s;
            // Gated by the synchronized lock so a pulse never extends past lock loss.
            o_phasestep = r_lock_s;
            if (!r_lock_s)
               w_next = S_ABORT;
            else if (r_cnt == C_PULSE)
               w_next = S_GAP;
         end
         S_GAP: begin
            o_busy   = 1'b1;
            o_locked = r_lock_s;
            if (!r_lock_s) begin
               w_next = S_ABORT;
            end else if (r_cnt == C_GAP) begin
               w_rem_dec = 1'b1;
`ifdef PLL_PHASE_SETTLE_EN
               w_next = (r_rem == STEPS_W'(1)) ? S_SETTLE : S_PULSE;
`else
               w_next = (r_rem == STEPS_W'(1)) ? S_DONE : S_PULSE;
`endif
            end
         end
`ifdef PLL_PHASE_SETTLE_EN
         S_SETTLE: begin
            o_busy   = 1'b1;
            o_locked = r_lock_s;
            if (!r_lock_s && r_low == 7'd63)
               w_next = S_ABORT;
            else if (r_lock_s && r_cnt == C_SETTLE)
               w_next = S_DONE;
         end
`endif
         S_DONE: begin
            o_busy   = 1'b1;
            o_locked = r_lock_s;
            o_done   = 1'b1;
            w_next   = r_lock_s ? S_IDLE : S_RESET;
         end
         S_ABORT: begin
            o_busy  = 1'b1;
            o_done  = 1'b1;
            o_abort = 1'b1;
            w_next  = S_RESET;
         end
         default: w_next = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb/tb_pll_phase_ctrl.sv - scoreboard bench for pll_phase_ctrl with a latency/pulse-window reference model
module tb_pll_phase_ctrl;

   localparam int SETUP = 2;
   localparam int PULSE = 2;
   localparam int GAP   = 4;
   localparam int RSTC  = 16;
   localparam int LTO   = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_sel = 2'd0;
   logic       req_dir = 1'b0;
   logic [7:0] req_steps = 8'd0;
   logic       pll_lock = 1'b0;
   logic       o_req_ready, o_done, o_abort, o_busy, o_locked, o_lock_err;
   logic       o_pll_rst, o_phasedir, o_phasestep;
   logic [1:0] o_phasesel;

   pll_phase_ctrl #(
      .STEPS_W(8), .STEP_SETUP(SETUP), .STEP_PULSE(PULSE), .STEP_GAP(GAP),
      .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LTO)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(o_req_ready),
      .i_req_sel(req_sel), .i_req_dir(req_dir), .i_req_steps(req_steps),
      .o_done(o_done), .o_abort(o_abort), .o_busy(o_busy),
      .o_locked(o_locked), .o_lock_err(o_lock_err),
      .i_pll_lock(pll_lock), .o_pll_rst(o_pll_rst),
      .o_phasesel(o_phasesel), .o_phasedir(o_phasedir), .o_phasestep(o_phasestep)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int         t;
      int         done_c;
      bit         abort;
      int         pulses;
      logic [1:0] sel;
      logic       dir;
   } exp_t;

   exp_t q[$];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic chk_rst_vals(input string name);
      check(name, int'({o_pll_rst, o_req_ready, o_done, o_abort, o_busy, o_locked,
                        o_lock_err, o_phasesel, o_phasedir, o_phasestep}), 1024);
   endtask

   function automatic int normal_done(input int t, input int n);
      return (n == 0) ? t + 1 : t + 1 + SETUP + n * (PULSE + GAP);
   endfunction

   function automatic int pulses_before(input int t, input int n, input int lim);
      int c = 0;
      for (int k = 0; k < n; k++)
         for (int j = 0; j < PULSE; j++)
            if (t + 1 + SETUP + k * (PULSE + GAP) + j < lim) c++;
      return c;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents o_done.
   initial begin
      int   pulse_hi = 0;
      int   busy_cnt = 0;
      bit   want_ready = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pulse_hi = 0; busy_cnt = 0; want_ready = 0;
         end else begin
            if (want_ready) begin
               check("ready_after_done", o_req_ready, 1);
               want_ready = 0;
            end
            if (o_busy) busy_cnt++;
            if (o_phasestep) begin
               pulse_hi++;
               if (q.size() == 0) check("step_without_req", 1, 0);
               else begin
                  check("step_sel", o_phasesel, q[0].sel);
                  check("step_dir", o_phasedir, q[0].dir);
               end
            end
            if (o_done) begin
               if (q.size() == 0) check("spurious_done", 1, 0);
               else begin
                  e = q.pop_front();
                  check("done_cycle", cyc, e.done_c);
                  check("done_abort", o_abort, e.abort);
                  check("step_high_cycles", pulse_hi, e.pulses);
                  check("busy_cycles", busy_cnt, e.done_c - e.t);
                  check("hold_sel", o_phasesel, e.sel);
                  check("hold_dir", o_phasedir, e.dir);
                  want_ready = !e.abort;
               end
               pulse_hi = 0; busy_cnt = 0;
            end
         end
      end
   end

   task automatic issue(input logic [1:0] s, input logic d, input int n, input int abort_d);
      int   waited = 0;
      int   nd;
      exp_t e;
      @(negedge clk);
      while (!o_req_ready && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      check("ready_wait", o_req_ready, 1);
      if (!o_req_ready) return;
      req_valid = 1'b1; req_sel = s; req_dir = d; req_steps = 8'(n);
      e.t = cyc; e.sel = s; e.dir = d;
      nd = normal_done(e.t, n);
      if (abort_d > 0 && n > 0 && e.t + abort_d < nd) begin
         e.done_c = e.t + abort_d + 1;
         e.abort  = 1'b1;
         e.pulses = pulses_before(e.t, n, e.t + abort_d);
      end else begin
         e.done_c = nd;
         e.abort  = 1'b0;
         e.pulses = n * PULSE;
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_sel = 2'($urandom); req_dir = 1'($urandom); req_steps = 8'($urandom);
      if (abort_d > 0) begin
         // Lock dropped two cycles before the synchronized copy falls.
         @(negedge clk);
         repeat (abort_d - 3) @(negedge clk);
         pll_lock = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int w = 0;
      while (q.size() != 0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      check("idle_wait", q.size(), 0);
   endtask

   task automatic abort_test(input int n, input int d);
      int w = 0;
      int cnt = 0;
      issue(2'($urandom), 1'($urandom), n, d);
      while (!o_pll_rst && w < 100) begin
         @(negedge clk);
         w++;
      end
      while (o_pll_rst && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      check("abort_rst_len", cnt, RSTC);
      check("locked_in_wait", o_locked, 0);
      pll_lock = 1'b1;
      w = 0;
      while (!o_req_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("recover_ready", o_req_ready, 1);
      check("lock_err_clear", o_lock_err, 0);
      check("abort_q_empty", q.size(), 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rst_hi = 0, last_hi = -1, first_rdy = -1;
      int first_err = -1, err_drop = 0, rise1 = -1, rise2 = -1, w;
      int n, nd;
      bit prev_rst;

      repeat (3) @(negedge clk);
      chk_rst_vals("reset_values");

      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_pll_rst) begin rst_hi++; last_hi = i; end
         if (o_req_ready && first_rdy < 0) first_rdy = i;
         if (i == 30) pll_lock = 1'b1;
      end
      check("startup_rst_cycles", rst_hi, RSTC);
      check("startup_rst_last", last_hi, RSTC - 1);
      check("startup_ready_cycle", first_rdy, 33);
      check("startup_locked", o_locked, 1);

      issue(2'd2, 1'b1, 3, 0);
      wait_idle();
      issue(2'd1, 1'b0, 0, 0);
      wait_idle();
      issue(2'd3, 1'b0, 255, 0);
      wait_idle();

      for (int i = 0; i < 14; i++) begin
         issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();

      abort_test(3, 10);
      n  = int'($urandom_range(1, 4));
      nd = normal_done(0, n);
      abort_test(n, int'($urandom_range(3, nd - 1)));

      issue(2'd1, 1'b1, 2, 0);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_rst_vals("async_reset_values");
      q.delete();
      repeat (3) @(negedge clk);
      chk_rst_vals("held_reset_values");
      @(posedge clk);
      #1 rst_n = 1'b1;
      issue(2'd0, 1'b1, 1, 0);
      wait_idle();

      @(posedge clk);
      #3 rst_n = 1'b0; pll_lock = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      prev_rst = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (o_lock_err && first_err < 0) first_err = i;
         if (first_err >= 0 && !o_lock_err) err_drop++;
         if (o_pll_rst && !prev_rst) begin
            if (rise1 < 0) rise1 = i;
            else if (rise2 < 0) rise2 = i;
         end
         prev_rst = o_pll_rst;
      end
      check("lock_err_cycle", first_err, RSTC + LTO);
      check("retry_rise1", rise1, RSTC + LTO);
      check("retry_rise2", rise2, 2 * (RSTC + LTO));
      check("lock_err_sticky", err_drop, 0);
      pll_lock = 1'b1;
      w = 0;
      while (!o_req_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      check("late_lock_ready", o_req_ready, 1);
      check("late_lock_err_kept", o_lock_err, 1);
      issue(2'd3, 1'b1, 2, 0);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
